hub75_scan_controller: RTL and testbench

HUB75_SCAN_CONTROLLER -- requirements
Module: hub75_scan_controller

---
 rtl/hub75_scan_controller.sv | 184 ++++++++++++++++++
 tb/tb_hub75_scan_controller.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/hub75_scan_controller.sv
// rtl/hub75_scan_controller.sv - HUB75 LED panel scan controller with binary-coded-modulation bit planes
// Optional feature macro: HUB75_DEAD_TIME_EN (stretches BLANK from 1 to 4 cycles before each latch)

module hub75_scan_controller #(
  parameter int column_count = 64,
  parameter int row_count    = 16,
  parameter int plane_count  = 8,
  parameter int base_on_time = 32
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            enable,
  input  logic                            pixel_valid,
  output logic                            pixel_ready,
  output logic [$clog2(column_count)-1:0] column,
  output logic [$clog2(row_count)-1:0]    shift_row,
  output logic [$clog2(plane_count)-1:0]  plane,
  output logic                            shift_clock,
  output logic                            latch,
  output logic                            output_enable_n,
  output logic [$clog2(row_count)-1:0]    row_address,
  output logic                            frame_done
);

  localparam int col_w   = $clog2(column_count);
  localparam int row_w   = $clog2(row_count);
  localparam int plane_w = $clog2(plane_count);

  // Longest display window belongs to the most significant plane.
  localparam int max_on_time = base_on_time << (plane_count - 1);
  localparam int disp_w      = $clog2(max_on_time + 1);

`ifdef HUB75_DEAD_TIME_EN
  // Extra blanking lets the row drivers settle before the address changes.
  localparam int blank_cycles = 4;
`else
  localparam int blank_cycles = 1;
`endif

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SHIFT_LOW  = 3'd1,
    SHIFT_HIGH = 3'd2,
    BLANK      = 3'd3,
    LATCH      = 3'd4,
    DISPLAY    = 3'd5
  } state_t;

  state_t state;
  state_t state_next;

  logic [disp_w-1:0] disp_count;
  logic [disp_w-1:0] on_time;
  logic [1:0]        blank_count;

  logic col_last;
  logic row_last;
  logic plane_last;
  logic disp_last;
  logic blank_last;

  // Position and timing terminal-count decodes.
  always_comb begin
    on_time    = disp_w'(base_on_time) << plane;
    col_last   = (column == col_w'(column_count - 1));
    row_last   = (shift_row == row_w'(row_count - 1));
    plane_last = (plane == plane_w'(plane_count - 1));
    disp_last  = (disp_count == on_time - 1'b1);
    blank_last = (blank_count == 2'(blank_cycles - 1));
  end

  // State register; reset forces IDLE so all decoded outputs go safe at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and state-decoded panel/handshake outputs.
  always_comb begin
    state_next      = state;
    pixel_ready     = 1'b0;
    shift_clock     = 1'b0;
    latch           = 1'b0;
    output_enable_n = 1'b1;
    frame_done      = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          state_next = SHIFT_LOW;
        end
      end
      SHIFT_LOW: begin
        pixel_ready = 1'b1;
        if (pixel_valid) begin
          state_next = SHIFT_HIGH;
        end
      end
      SHIFT_HIGH: begin
        shift_clock = 1'b1;
        state_next  = col_last ? BLANK : SHIFT_LOW;
      end
      BLANK: begin
        if (blank_last) begin
          state_next = LATCH;
        end
      end
      LATCH: begin
        latch      = 1'b1;
        state_next = DISPLAY;
      end
      DISPLAY: begin
        output_enable_n = 1'b0;
        if (disp_last) begin
          if (row_last && plane_last) begin
            // Enable is only honoured at frame boundaries, never mid-frame.
            frame_done = 1'b1;
            state_next = enable ? SHIFT_LOW : IDLE;
          end else begin
            state_next = SHIFT_LOW;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Scan position, latched row address and blank/display interval counters.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      column      <= '0;
      shift_row   <= '0;
      plane       <= '0;
      row_address <= '0;
      disp_count  <= '0;
      blank_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            column    <= '0;
            shift_row <= '0;
            plane     <= '0;
          end
        end
        SHIFT_HIGH: begin
          column <= col_last ? '0 : column + 1'b1;
        end
        BLANK: begin
          if (blank_last) begin
            blank_count <= '0;
            // Loaded on entry to LATCH so the panel sees the new address with the strobe.
            row_address <= shift_row;
          end else begin
            blank_count <= blank_count + 1'b1;
          end
        end
        LATCH: begin
          disp_count <= '0;
        end
        DISPLAY: begin
          if (disp_last) begin
            disp_count <= '0;
            if (plane_last) begin
              plane     <= '0;
              shift_row <= row_last ? '0 : shift_row + 1'b1;
            end else begin
              plane <= plane + 1'b1;
            end
          end else begin
            disp_count <= disp_count + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hub75_scan_controller.sv
// tb/tb_hub75_scan_controller.sv - self-checking bench for hub75_scan_controller (4 cols, 2 rows, 2 planes)

module tb_hub75_scan_controller;

  localparam int col_n   = 4;
  localparam int row_n   = 2;
  localparam int plane_n = 2;
  localparam int base_on = 3;
`ifdef HUB75_DEAD_TIME_EN
  localparam int blank_len = 4;
`else
  localparam int blank_len = 1;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic       pixel_valid;
  logic       pixel_ready;
  logic [1:0] column;
  logic [0:0] shift_row;
  logic [0:0] plane;
  logic       shift_clock;
  logic       latch;
  logic       output_enable_n;
  logic [0:0] row_address;
  logic       frame_done;

  int checks = 0;
  int errors = 0;
  int ra_model = 0;

  hub75_scan_controller #(
    .column_count(col_n),
    .row_count(row_n),
    .plane_count(plane_n),
    .base_on_time(base_on)
  ) dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .pixel_valid(pixel_valid),
    .pixel_ready(pixel_ready),
    .column(column),
    .shift_row(shift_row),
    .plane(plane),
    .shift_clock(shift_clock),
    .latch(latch),
    .output_enable_n(output_enable_n),
    .row_address(row_address),
    .frame_done(frame_done)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic expect_now(input string tag, input bit pr, input int col, input int sr,
                            input int pl, input bit sc, input bit la, input bit oen,
                            input int ra, input bit fd);
    logic [9:0] obs;
    logic [9:0] exp;
    obs = {pixel_ready, column, shift_row, plane, shift_clock, latch, output_enable_n,
           row_address, frame_done};
    exp = {pr, 2'(col), 1'(sr), 1'(pl), sc, la, oen, 1'(ra), fd};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b (pr col row plane sclk lat oen addr fdone)",
             tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input bit pr, input int col, input int sr,
                            input int pl, input bit sc, input bit la, input bit oen,
                            input int ra, input bit fd);
    @(negedge clock);
    expect_now(tag, pr, col, sr, pl, sc, la, oen, ra, fd);
  endtask

  // One frame as the panel should see it: per row, per plane, shift every column,
  // blank, latch the row, then light for base_on<<plane cycles.
  // mode 0: pixel_valid always high; 1: five-cycle stall at column 2; 2: random.
  task automatic run_frame(input int mode, input int drop_r, input int drop_p, input bit abort);
    for (int r = 0; r < row_n; r++) begin
      for (int p = 0; p < plane_n; p++) begin
        if (r == drop_r && p == drop_p) enable = 1'b0;
        for (int c = 0; c < col_n; c++) begin
          int zeros;
          bit pv;
          zeros = 0;
          while (1'b1) begin
            expect_out("shift_low", 1, c, r, p, 0, 0, 1, ra_model, 0);
            if (mode == 1 && r == 0 && p == 0 && c == 2) pv = (zeros >= 5);
            else if (mode == 2) pv = ($urandom_range(0, 2) != 0) || (zeros >= 6);
            else pv = 1'b1;
            pixel_valid = pv;
            if (pv) break;
            zeros++;
          end
          expect_out("shift_high", 0, c, r, p, 1, 0, 1, ra_model, 0);
          pixel_valid = 1'($urandom_range(0, 1));
        end
        for (int b = 0; b < blank_len; b++) begin
          expect_out("blank", 0, 0, r, p, 0, 0, 1, ra_model, 0);
        end
        ra_model = r;
        expect_out("latch", 0, 0, r, p, 0, 1, 1, ra_model, 0);
        for (int d = 0; d < (base_on << p); d++) begin
          bit fd;
          fd = (d == (base_on << p) - 1) && (r == row_n - 1) && (p == plane_n - 1);
          expect_out("display", 0, 0, r, p, 0, 0, 0, ra_model, fd);
          if (abort && r == 0 && p == 0 && d == 1) begin
            #1 reset = 1'b1;
            #1;
            ra_model = 0;
            expect_now("async_reset", 0, 0, 0, 0, 0, 0, 1, 0, 0);
            return;
          end
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b0;
    pixel_valid = 1'b0;
    repeat (2) @(negedge clock);
    expect_now("reset_state", 0, 0, 0, 0, 0, 0, 1, 0, 0);
    reset = 1'b0;
    expect_out("idle_disabled", 0, 0, 0, 0, 0, 0, 1, 0, 0);
    expect_out("idle_start", 0, 0, 0, 0, 0, 0, 1, 0, 0);
    enable = 1'b1;

    run_frame(0, -1, -1, 1'b0);
    run_frame(1, -1, -1, 1'b0);
    run_frame(2, 0, 1, 1'b0);
    repeat (3) expect_out("idle_after_drop", 0, 0, 0, 0, 0, 0, 1, ra_model, 0);
    enable = 1'b1;

    run_frame(2, -1, -1, 1'b1);
    expect_out("reset_held", 0, 0, 0, 0, 0, 0, 1, 0, 0);
    reset = 1'b0;
    run_frame(0, -1, -1, 1'b0);
    run_frame(2, -1, -1, 1'b0);
    run_frame(2, 1, 0, 1'b0);
    repeat (2) expect_out("idle_final", 0, 0, 0, 0, 0, 0, 1, ra_model, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
